sram16k32_arbiter: RTL

- Two-requester round-robin access controller in front of one sram16k32 instance (16 K x 32, synchronous read, 1-cycle latency, single we).
- Accepts one request at a time over a valid/ready handshake.
- Sequences the SRAM address, write and read-capture cycles, and returns read data to the requester with a tagged one-cycle response pulse.
- Sits between the CPU-side and DMA-side masters and the shared memory macro.

---
 rtl/sram16k32_arbiter_pkg.sv | 16 +
 rtl/sram16k32_arbiter_if.sv | 27 ++
 rtl/sram16k32_arbiter_rr_arbiter2.sv | 21 ++
 rtl/sram16k32_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/sram16k32_arbiter_pkg.sv
// Shared types and widths for the sram16k32 access controller.
package sram_ctrl_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/sram16k32_arbiter_if.sv
// Requester-side bus: two request ports sharing one tagged response path.
interface sram16k32_arbiter_if #(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sram_ctrl_pkg::DATA_W
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram16k32_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the caller owns last_grant.
module rr_arbiter2 import sram_ctrl_pkg::*; (
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/sram16k32_arbiter.sv
// Round-robin controller sequencing single accesses to one sram16k32 macro.
module sram16k32_arbiter #(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sram_ctrl_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram16k32_arbiter_if.slave  bus,
  output logic                busy,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  import sram_ctrl_pkg::*;

  state_t            state, state_nx;
  port_id_t          op_id, last_grant, hs_id;
  logic              op_we, hs;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata, rsp_rdata_q;
  logic [1:0]        cnt, grant, rsp_valid_c;

  rr_arbiter2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .enable     (state == IDLE && !rst),
    .grant      (grant)
  );

  assign bus.req_ready = grant;
  assign hs            = |(bus.req_valid & grant);
  assign hs_id         = grant[1];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = ACCESS;
      ACCESS:  state_nx = op_we ? IDLE : WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      op_id       <= 1'b0;
      op_we       <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
      cnt         <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        op_id      <= hs_id;
        op_we      <= bus.req_we[hs_id];
        op_addr    <= hs_id ? bus.req_addr1  : bus.req_addr0;
        op_wdata   <= hs_id ? bus.req_wdata1 : bus.req_wdata0;
        last_grant <= hs_id;
      end
      if (state == ACCESS)
        cnt <= 2'(RD_LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 2'd1;
      if (state == WAIT && cnt == '0)
        rsp_rdata_q <= sram_rdata;
    end
  end

  // Address stays on op_addr through WAIT: the macro's output mux follows the live upper bits.
  // we is gated by rst combinationally so a reset cycle landing on ACCESS never writes.
  always_comb begin
    rsp_valid_c = '0;
    if (state == RESP) rsp_valid_c[op_id] = 1'b1;
    busy       = (state != IDLE);
    sram_we    = (state == ACCESS) && op_we && !rst;
    sram_addr  = op_addr;
    sram_wdata = op_wdata;
  end

  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
